// File: rtl/calc_bcd_n.sv
// calc_bcd_n: DIGITS-wide signed BCD add/subtract keypad calculator.
// Ports: CLK, RST (sync, active-low), push/plus/minus/equal/ce
// (active-low buttons); led (7 seg per digit), sign, overflow.
module calc_bcd_n #(
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [9:0]            push,
  input  logic                  plus,
  input  logic                  minus,
  input  logic                  equal,
  input  logic                  ce,
  output logic [7*DIGITS-1:0]   led,
  output logic                  sign,
  output logic                  overflow
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [2:0] {
    ENTRY_A, OPWAIT, ENTRY_B, RESULT, ERR
  } state_t;

  state_t         r_state, w_state;
  logic [13:0]    r_cur, r_prv;
  logic [W-1:0]   r_acc, w_acc;
  logic           r_asgn, w_asgn;
  logic [W-1:0]   r_ent, w_ent;
  logic           r_op, w_op;
  logic [W-1:0]   r_lop, w_lop;

  logic [13:0]    w_ev;
  logic [3:0]     w_d;
  logic [W-1:0]   w_b;
  logic           w_bs;
  logic [W-1:0]   w_mag;
  logic           w_rsgn;
  logic           w_ovf;
  logic [W-1:0]   w_val;
  logic           w_vsgn;
  logic [7*DIGITS-1:0] w_led;

  function automatic logic [W:0] f_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] r;
    logic       c;
    logic [4:0] s;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0, c};
      c = (s > 5'd9);
      if (c) s = s + 5'd6;
      r[4*i+:4] = s[3:0];
    end
    r[W] = c;
    return r;
  endfunction

  // a >= b is required; each digit borrows by adding 10 mod 32
  function automatic logic [W-1:0] f_sub(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] r;
    logic         bw;
    logic [4:0]   s;
    r  = '0;
    bw = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      s  = {1'b0, a[4*i+:4]} - {1'b0, b[4*i+:4]} - {4'b0, bw};
      bw = s[4];
      if (bw) s = s + 5'd10;
      r[4*i+:4] = s[3:0];
    end
    return r;
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // bit 13 ce, 12 equal, 11 plus, 10 minus, 9..0 digits
  assign w_ev = r_prv & ~r_cur;

  always_comb begin
    w_d = 4'd0;
    for (int i = 9; i >= 0; i--)
      if (w_ev[i]) w_d = 4'(i);
  end

  // repeat-equals reuses lop, everything else uses entry
  assign w_b  = (r_state == RESULT) ? r_lop : r_ent;
  assign w_bs = r_op;

  always_comb begin
    w_ovf  = 1'b0;
    w_mag  = '0;
    w_rsgn = 1'b0;
    if (r_asgn == w_bs) begin
      {w_ovf, w_mag} = f_add(r_acc, w_b);
      w_rsgn = r_asgn;
    end else if (r_acc >= w_b) begin
      w_mag  = f_sub(r_acc, w_b);
      w_rsgn = r_asgn;
    end else begin
      w_mag  = f_sub(w_b, r_acc);
      w_rsgn = w_bs;
    end
    if (w_mag == '0) w_rsgn = 1'b0;
  end

  always_comb begin
    w_state = r_state;
    w_acc   = r_acc;
    w_asgn  = r_asgn;
    w_ent   = r_ent;
    w_op    = r_op;
    w_lop   = r_lop;
    if (w_ev[13]) begin
      w_state = ENTRY_A;
      w_acc   = '0;
      w_asgn  = 1'b0;
      w_ent   = '0;
      w_op    = 1'b0;
      w_lop   = '0;
    end else if (w_ev[12]) begin
      case (r_state)
        ENTRY_A: begin
          w_acc   = r_ent;
          w_asgn  = 1'b0;
          w_lop   = '0;
          w_state = RESULT;
        end
        ENTRY_B, RESULT: begin
          if (r_state == ENTRY_B) w_lop = r_ent;
          if (w_ovf) begin
            w_state = ERR;
          end else begin
            w_acc   = w_mag;
            w_asgn  = w_rsgn;
            w_state = RESULT;
          end
        end
        default: ;
      endcase
    end else if (w_ev[11] || w_ev[10]) begin
      if (r_state != ERR) begin
        w_op    = ~w_ev[11];
        w_state = OPWAIT;
        if (r_state == ENTRY_A) begin
          w_acc  = r_ent;
          w_asgn = 1'b0;
        end else if (r_state == ENTRY_B) begin
          if (w_ovf) begin
            w_state = ERR;
            w_op    = r_op;
          end else begin
            w_acc  = w_mag;
            w_asgn = w_rsgn;
          end
        end
      end
    end else if (|w_ev[9:0]) begin
      case (r_state)
        ENTRY_A, ENTRY_B: begin
          if (r_ent[W-1 -: 4] == 4'd0)
            w_ent = {r_ent[W-5:0], w_d};
        end
        OPWAIT: begin
          w_ent   = {{(W-4){1'b0}}, w_d};
          w_state = ENTRY_B;
        end
        RESULT: begin
          w_ent   = {{(W-4){1'b0}}, w_d};
          w_asgn  = 1'b0;
          w_state = ENTRY_A;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    logic seen;
    seen   = 1'b0;
    w_led  = '0;
    w_val  = w_acc;
    w_vsgn = w_asgn;
    if (w_state == ENTRY_A || w_state == ENTRY_B) begin
      w_val  = w_ent;
      w_vsgn = 1'b0;
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (w_val[4*i+:4] != 4'd0) seen = 1'b1;
      if (w_state == ERR)
        w_led[7*i+:7] = 7'h40;
      else if (seen || i == 0)
        w_led[7*i+:7] = f_seg(w_val[4*i+:4]);
    end
    if (w_state == ERR) w_vsgn = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cur    <= '1;
      r_prv    <= '1;
      r_state  <= ENTRY_A;
      r_acc    <= '0;
      r_asgn   <= 1'b0;
      r_ent    <= '0;
      r_op     <= 1'b0;
      r_lop    <= '0;
      led      <= {{(7*(DIGITS-1)){1'b0}}, 7'h3F};
      sign     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_cur    <= {ce, equal, plus, minus, push};
      r_prv    <= r_cur;
      r_state  <= w_state;
      r_acc    <= w_acc;
      r_asgn   <= w_asgn;
      r_ent    <= w_ent;
      r_op     <= w_op;
      r_lop    <= w_lop;
      led      <= w_led;
      sign     <= w_vsgn;
      overflow <= (w_state == ERR);
    end
  end

endmodule

// File: tb/tb_calc_bcd_n.sv
// tb_calc_bcd_n: scoreboard bench for calc_bcd_n at DIGITS 4, 2, 6.
// All three instances share the same button stimulus.
module tb_calc_bcd_n;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [9:0]  push = '1;
  logic        plus = 1'b1;
  logic        minus = 1'b1;
  logic        equal = 1'b1;
  logic        ce = 1'b1;

  logic [27:0] led4;
  logic [13:0] led2;
  logic [41:0] led6;
  logic        sg4, sg2, sg6, ov4, ov2, ov6;

  always #5 CLK = ~CLK;

  calc_bcd_n #(.DIGITS(4)) u4 (
    .CLK(CLK), .RST(RST), .push(push), .plus(plus), .minus(minus),
    .equal(equal), .ce(ce), .led(led4), .sign(sg4), .overflow(ov4));
  calc_bcd_n #(.DIGITS(2)) u2 (
    .CLK(CLK), .RST(RST), .push(push), .plus(plus), .minus(minus),
    .equal(equal), .ce(ce), .led(led2), .sign(sg2), .overflow(ov2));
  calc_bcd_n #(.DIGITS(6)) u6 (
    .CLK(CLK), .RST(RST), .push(push), .plus(plus), .minus(minus),
    .equal(equal), .ce(ce), .led(led6), .sign(sg6), .overflow(ov6));

  typedef struct packed {
    int              due;
    logic [2:0][41:0] led;
    logic [2:0]      sg;
    logic [2:0]      ov;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  localparam int S_EA = 0, S_OW = 1, S_EB = 2, S_RES = 3, S_ERR = 4;
  localparam int K_DIG = 0, K_MIN = 1, K_PLS = 2, K_EQ = 3, K_CE = 4;

  int nd[3] = '{4, 2, 6};
  int st[3], acc[3], ent[3], op[3], lop[3];

  function automatic int pw(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [6:0] seg(input int n);
    logic [6:0] t[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[n];
  endfunction

  function automatic logic [41:0] m_led(input int k);
    logic [41:0] r = '0;
    int v;
    if (st[k] == S_ERR) begin
      for (int i = 0; i < nd[k]; i++) r[7*i+:7] = 7'h40;
    end else begin
      v = (st[k] == S_EA || st[k] == S_EB) ? ent[k] : iabs(acc[k]);
      for (int i = 0; i < nd[k]; i++)
        if (i == 0 || v >= pw(i)) r[7*i+:7] = seg((v / pw(i)) % 10);
    end
    return r;
  endfunction

  function automatic void m_apply(input int k, input int kind, input int d);
    int mx = pw(nd[k]) - 1;
    int r;
    case (kind)
      K_CE: begin
        st[k] = S_EA; acc[k] = 0; ent[k] = 0; op[k] = 1; lop[k] = 0;
      end
      K_DIG: begin
        if (st[k] == S_EA || st[k] == S_EB) begin
          if (ent[k] < pw(nd[k] - 1)) ent[k] = ent[k] * 10 + d;
        end else if (st[k] == S_OW) begin
          ent[k] = d; st[k] = S_EB;
        end else if (st[k] == S_RES) begin
          ent[k] = d; acc[k] = iabs(acc[k]); st[k] = S_EA;
        end
      end
      K_MIN, K_PLS: begin
        if (st[k] != S_ERR) begin
          if (st[k] == S_EA) acc[k] = ent[k];
          if (st[k] == S_EB) begin
            r = acc[k] + op[k] * ent[k];
            if (iabs(r) > mx) st[k] = S_ERR;
            else acc[k] = r;
          end
          if (st[k] != S_ERR) begin
            op[k] = (kind == K_PLS) ? 1 : -1;
            st[k] = S_OW;
          end
        end
      end
      K_EQ: begin
        if (st[k] == S_EA) begin
          acc[k] = ent[k]; lop[k] = 0; st[k] = S_RES;
        end else if (st[k] == S_EB || st[k] == S_RES) begin
          if (st[k] == S_EB) lop[k] = ent[k];
          r = acc[k] + op[k] * lop[k];
          if (iabs(r) > mx) st[k] = S_ERR;
          else begin acc[k] = r; st[k] = S_RES; end
        end
      end
      default: ;
    endcase
  endfunction

  function automatic exp_t m_snap(input int due);
    exp_t x;
    x.due = due;
    for (int k = 0; k < 3; k++) begin
      x.led[k] = m_led(k);
      x.sg[k]  = (st[k] == S_OW || st[k] == S_RES) && acc[k] < 0;
      x.ov[k]  = (st[k] == S_ERR);
    end
    return x;
  endfunction

  task automatic chk(input int k, input logic [41:0] gl,
                     input logic gs, input logic go);
    n_chk++;
    if (gl !== e.led[k] || gs !== e.sg[k] || go !== e.ov[k]) begin
      n_fail++;
      $display("FAIL disp_d%0d cyc=%0d got led=%h sign=%b ovf=%b want led=%h sign=%b ovf=%b",
               nd[k], cyc, gl, gs, go, e.led[k], e.sg[k], e.ov[k]);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL late_item due=%0d now=%0d", e.due, cyc);
      end else begin
        chk(0, {14'b0, led4}, sg4, ov4);
        chk(1, {28'b0, led2}, sg2, ov2);
        chk(2, led6, sg6, ov6);
      end
    end
  end

  task automatic do_rst();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 3; k++) m_apply(k, K_CE, 0);
    q.push_back(m_snap(cyc + 1));
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  // m: 13 ce, 12 equal, 11 plus, 10 minus, 9..0 digits
  task automatic press(input logic [13:0] m, input int hold, input int gap);
    int kind, d;
    kind = K_DIG;
    d = 0;
    if (m[13]) kind = K_CE;
    else if (m[12]) kind = K_EQ;
    else if (m[11]) kind = K_PLS;
    else if (m[10]) kind = K_MIN;
    else begin
      for (int i = 9; i >= 0; i--) if (m[i]) d = i;
    end
    @(negedge CLK);
    {ce, equal, plus, minus, push} = ~m;
    for (int k = 0; k < 3; k++) m_apply(k, kind, d);
    q.push_back(m_snap(cyc + 2));
    repeat (hold) @(negedge CLK);
    {ce, equal, plus, minus, push} = '1;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic dig(input int d);
    press(14'(1) << d, 1, 5);
  endtask

  task automatic key(input int b);
    press(14'(1) << b, 1, 5);
  endtask

  localparam int B_MIN = 10, B_PLS = 11, B_EQ = 12, B_CE = 13;

  initial begin
    logic [13:0] m;
    do_rst();
    dig(1); key(B_PLS); dig(1); key(B_EQ);
    do_rst();
    dig(3); key(B_MIN); dig(5); key(B_EQ);
    key(B_PLS); dig(2); key(B_EQ);
    key(B_CE);
    dig(1); key(B_PLS); dig(2); key(B_PLS); dig(3);
    key(B_EQ); key(B_EQ); key(B_EQ);
    key(B_CE);
    dig(9); dig(9); dig(9); dig(9); key(B_PLS); dig(1); key(B_EQ);
    key(B_PLS); dig(5);
    key(B_CE);
    dig(1); dig(2); dig(3); dig(4); dig(5); dig(6); dig(7);
    key(B_CE);
    press(14'(1) << 7, 10, 5);
    press((14'(1) << B_CE) | (14'(1) << 3), 2, 5);
    dig(4);
    press((14'(1) << B_CE) | (14'(1) << 3), 2, 5);
    dig(5); key(B_PLS);
    do_rst();
    dig(2); key(B_EQ);
    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 50) m = 14'(1) << $urandom_range(0, 9);
      else if (r < 62) m = 14'(1) << B_PLS;
      else if (r < 74) m = 14'(1) << B_MIN;
      else if (r < 88) m = 14'(1) << B_EQ;
      else if (r < 92) m = 14'(1) << B_CE;
      else m = 14'($urandom_range(1, 16383));
      if (r == 99) do_rst();
      else press(m, $urandom_range(1, 4), $urandom_range(1, 3));
    end
    for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge CLK);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_bcd_n.md
Name: calc_bcd_n

Overview:
- Parametrised successor to the two-digit calculator top: a DIGITS-wide signed decimal add/subtract calculator.
- Inputs are active-low keypad buttons; outputs are 7-segment digit patterns plus sign and overflow flags.
- Adds operator chaining, repeat-equals and a latched error state.
- Sits between the board's button inputs and the seven-segment display drivers.

Parameters:
- DIGITS, 4, number of decimal digits held and displayed; MAX = 10^DIGITS-1.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-low reset.
- push  in  10  active-low digit buttons; bit i = digit i.
- plus  in  1  active-low "+" button.
- minus  in  1  active-low "-" button.
- equal  in  1  active-low "=" button.
- ce  in  1  active-low clear-all button.
- led  out  7*DIGITS  segment patterns, active-high, bit0=a..bit6=g; digit d (0=LS) at [7d+6:7d].
- sign  out  1  1 = displayed value negative.
- overflow  out  1  1 = error state; result exceeded MAX.

Behaviour:
- Reset (RST low at edge): all state cleared, FSM=ENTRY_A.
  - led digit0=7'h3F ("0"), other digits 7'h00, sign=0, overflow=0.
- Input capture: every button registered once per edge (cur). Previous sample kept (prv).
  - Press event = prv high and cur low, i.e. falling edge only.
  - A held button produces exactly one event. Release produces none.
- Latency: a button first sampled low at edge k changes outputs at edge k+1.
- Priority when events coincide in one cycle: ce > equal > plus > minus > lowest-index digit. Only the winning event acts; the rest are discarded.
- Storage: acc (BCD magnitude + acc_sign), entry (BCD), op (ADD/SUB), last operand lop (BCD). All magnitudes are DIGITS BCD nibbles.
- FSM states: ENTRY_A, OPWAIT, ENTRY_B, RESULT, ERR.
- Digit event:
  - ENTRY_A/ENTRY_B: entry = entry*10 + d. Ignored if entry already has DIGITS significant digits.
  - OPWAIT: entry = d, go to ENTRY_B.
  - RESULT: entry = d, acc_sign = 0, go to ENTRY_A.
  - ERR: ignored.
- plus/minus event:
  - ENTRY_A: acc = entry, acc_sign = 0.
  - ENTRY_B: acc = acc op entry (chained evaluation).
  - OPWAIT: replaces the pending op only.
  - RESULT: keeps acc.
  - In all of the above: op = new operator, go to OPWAIT. ERR: ignored.
- equal event:
  - ENTRY_B: lop = entry, acc = acc op entry, go to RESULT.
  - ENTRY_A: acc = entry, lop = 0, go to RESULT.
  - RESULT: acc = acc op lop (repeat-equals).
  - OPWAIT and ERR: ignored.
- ce event: identical to reset from any state.
- Arithmetic (sign-magnitude BCD):
  - Operand b = entry with sign 0 for ADD, 1 for SUB.
  - Equal signs: magnitudes added, sign kept.
  - Unequal signs: smaller magnitude subtracted from larger; result takes the sign of the larger.
  - Equal magnitudes: result 0, sign 0. Negative zero never produced.
  - Result magnitude > MAX: go to ERR, overflow=1. acc unchanged.
- Display:
  - ENTRY_A/ENTRY_B show entry with sign=0.
  - OPWAIT/RESULT show acc with sign=acc_sign.
  - ERR shows every digit 7'h40 ("-"), sign=0.
  - Leading zeros blanked (7'h00); digit0 always shown.
  - Digit encodings 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- Outputs are registered.
- Reset or ce mid-entry, mid-chain or in ERR returns to the reset state on that edge.

Test Plan:
- Reset, then 1, +, 1, =, with 5-cycle gaps → after "=": led[6:0]=7'h5B, upper digits 7'h00, sign=0, overflow=0. After "+", display still shows 1 (7'h06).
- 3, -, 5, = → led[6:0]=7'h5B, sign=1. Then +, 2, = → led[6:0]=7'h3F ("0"), sign=0.
- Chain and repeat: 1, +, 2, +, 3, = → display 3 after the second "+", 6 after "=". A further "=" gives 9; another "=" gives led[13:0]={7'h06,7'h5B} ("12").
- Overflow (DIGITS=4): 9,9,9,9,+,1,= → overflow=1, all four digits 7'h40. Subsequent "+" and digit presses leave outputs unchanged. ce → reset outputs.
- Entry limit and held key:
  - Digits 1,2,3,4,5 → display 1234.
  - Digit 7 held low for 10 cycles after ce → display 7 only.
  - ce and digit 3 falling in the same cycle → ce wins, display 0.
- Rerun the first scenario with DIGITS=2 and DIGITS=6. Then 5, +, RST low one cycle, then 2, = → display 2, sign=0 (pending op lost).
